// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter/sequencer sharing one single-port vector RAM among NUM_REQ requesters.
// Latency: grant and RAM drive are combinational; read data and o_rsp_valid are registered, 1 cycle after accept.
// Backpressure: o_req_ready is a one-hot grant. An ungranted requester holds its beat until it is granted.
// Optional feature macro RAM_ARB_LOCK_EN: burst lock, at most LOCK_MAX consecutive beats per lock.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_req_valid/we/lock [NUM_REQ], i_req_addr [NUM_REQ*ADDR_WIDTH], i_req_wdata [NUM_REQ*VEC_WIDTH]
//   o_req_ready [NUM_REQ] grant, o_rsp_valid [NUM_REQ] read strobe, o_rsp_data [VEC_WIDTH]
//   o_ram_we/addr/data to RAM, i_ram_data from RAM (combinational read of o_ram_addr)
module ram_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int VEC_WIDTH  = 264,
  parameter int ARR_DEPTH  = 2048,
  parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
  parameter int LOCK_MAX   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*VEC_WIDTH-1:0]  i_req_wdata,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [VEC_WIDTH-1:0]          o_rsp_data,
  output logic                          o_ram_we,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr,
  output logic [VEC_WIDTH-1:0]          o_ram_data,
  input  logic [VEC_WIDTH-1:0]          i_ram_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic             gnt_vld;

`ifdef RAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             lock_vld_q;
  logic [PTR_W-1:0] lock_idx_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [CNT_W-1:0] lock_cnt_nxt;
  logic             lock_hold;

  // The lock owner keeps the grant only while it keeps both valid and lock up.
  assign lock_hold    = lock_vld_q && i_req_valid[lock_idx_q] && i_req_lock[lock_idx_q];
  assign lock_cnt_nxt = lock_cnt_q + 1'b1;
`else
  logic unused_lock;
  assign unused_lock = ^{i_req_lock, 32'(LOCK_MAX)};
`endif

  // Round-robin search from the pointer upward, wrapping at NUM_REQ.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!gnt_vld && i_req_valid[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
`ifdef RAM_ARB_LOCK_EN
    if (lock_hold) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx_q;
    end
`endif
    // Nothing is granted or written while reset is held.
    if (i_rst) gnt_vld = 1'b0;
  end

  assign ptr_nxt     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign o_req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign o_ram_we    = gnt_vld & i_req_we[gnt_idx];
  assign o_ram_addr  = gnt_vld ? i_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_ram_data  = gnt_vld ? i_req_wdata[gnt_idx*VEC_WIDTH +: VEC_WIDTH] : '0;

  // A grant always coincides with a valid beat, so gnt_vld is the accept strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
`ifdef RAM_ARB_LOCK_EN
      lock_vld_q  <= 1'b0;
      lock_idx_q  <= '0;
      lock_cnt_q  <= '0;
`endif
    end else begin
      o_rsp_valid <= '0;
      if (gnt_vld) begin
        // While locked the owner is fixed, so this write leaves the pointer at owner+1.
        ptr_q <= ptr_nxt;
        if (!i_req_we[gnt_idx]) begin
          o_rsp_valid <= o_req_ready;
          o_rsp_data  <= i_ram_data;
        end
      end
`ifdef RAM_ARB_LOCK_EN
      if (lock_hold) begin
        if (lock_cnt_nxt >= CNT_W'(LOCK_MAX)) begin
          lock_vld_q <= 1'b0;
          lock_cnt_q <= '0;
        end else begin
          lock_cnt_q <= lock_cnt_nxt;
        end
      end else if (gnt_vld && i_req_lock[gnt_idx] && LOCK_MAX > 1) begin
        // First locked beat counts toward LOCK_MAX.
        lock_vld_q <= 1'b1;
        lock_idx_q <= gnt_idx;
        lock_cnt_q <= CNT_W'(1);
      end else begin
        lock_vld_q <= 1'b0;
        lock_cnt_q <= '0;
      end
`endif
    end
  end

endmodule
